// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_pkg
// Purpose  : Shared definitions for the sp_ram_array storage macro:
//            clear-sequencer state encoding, read-during-write mode
//            constants and a lane-count helper.
// Revision : 1.0  initial release
// ============================================================================
package sp_ram_pkg;

  // Clear sequencer states
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Read-during-write behaviour selectors
  localparam int unsigned RD_FIRST = 0;  // return the pre-write word
  localparam int unsigned WR_FIRST = 1;  // return the merged post-write word

  // Number of write-enable lanes in a word
  function automatic int unsigned calc_num_lanes(input int unsigned data_w,
                                                 input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

endpackage : sp_ram_pkg
`default_nettype wire

// File: rtl/sp_ram_clr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_clr_ctrl
// Purpose  : Clear sequencer. Sweeps every word of the array once after
//            reset and again on each clr_req seen while READY.
// Ports    : clka        - clock
//            rsta        - asynchronous active-low reset
//            clr_req     - pulse requesting a new sweep (ignored while busy)
//            busy        - sweep in progress, user accesses are blocked
//            sweep_addr  - word being cleared this cycle
//            sweep_we    - write strobe for the sweep port
// Revision : 1.0  initial release
// ============================================================================
module sp_ram_clr_ctrl
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nxt;

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy        = 1'b0;
    sweep_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        // The last word is written in the same cycle the FSM leaves CLEAR,
        // so the sweep occupies exactly 2**ADDR_W cycles.
        busy     = 1'b1;
        sweep_we = 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt   = ST_READY;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  assign sweep_addr = clr_cnt;

endmodule : sp_ram_clr_ctrl
`default_nettype wire

// File: rtl/sp_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_array
// Purpose  : Parametrised single-port RAM with per-lane write enables,
//            selectable read-during-write mode, registered read data with
//            a valid strobe and a built-in clear sweep.
// Ports    : clka      - clock
//            rsta      - asynchronous active-low reset
//            ena       - access request
//            wea       - per-lane write mask (all zero = read)
//            addra     - word address
//            dina      - write data
//            clr_req   - pulse starting a clear sweep
//            douta     - registered read data (holds when douta_vld=0)
//            douta_vld - one-cycle pulse per accepted access
//            busy      - clear sweep in progress
// Build    : SP_RAM_ARRAY_OUTREG_EN adds a second output register stage
//            (read latency 2 instead of 1).
// Revision : 1.0  initial release
// ============================================================================
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int unsigned       DATA_W  = 72,
  parameter int unsigned       ADDR_W  = 10,
  parameter int unsigned       LANE_W  = 8,
  parameter int unsigned       RD_MODE = RD_FIRST,
  parameter logic [LANE_W-1:0] CLR_VAL = '0,
  localparam int unsigned      NUM_LANES = calc_num_lanes(DATA_W, LANE_W)
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 ena,
  input  logic [NUM_LANES-1:0] wea,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [DATA_W-1:0]    dina,
  input  logic                 clr_req,
  output logic [DATA_W-1:0]    douta,
  output logic                 douta_vld,
  output logic                 busy
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] CLR_WORD = {NUM_LANES{CLR_VAL}};

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_word;

  sp_ram_clr_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clr_ctrl (
    .clka       (clka),
    .rsta       (rsta),
    .clr_req    (clr_req),
    .busy       (busy),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we)
  );

  // Accesses arriving during a sweep are dropped entirely.
  assign accept = ena & ~busy;

  assign rd_old = mem[addra];

  // Merged word: enabled lanes from dina, the rest from the current contents.
  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      assign wr_merged[l*LANE_W +: LANE_W] =
        wea[l] ? dina[l*LANE_W +: LANE_W] : rd_old[l*LANE_W +: LANE_W];
    end
  endgenerate

  // Sweep and user port never overlap (sweep_we implies busy), so the
  // sweep simply wins the shared write port.
  assign mem_we    = sweep_we | (accept & (|wea));
  assign mem_addr  = sweep_we ? sweep_addr : addra;
  assign mem_wdata = sweep_we ? CLR_WORD   : wr_merged;

  // Storage has no reset; the clear sweep initialises it. Edges while rsta
  // is held only rewrite word 0 with the clear value.
  always_ff @(posedge clka) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  generate
    if (RD_MODE == WR_FIRST) begin : g_wr_first
      assign rd_word = wr_merged;
    end else begin : g_rd_first
      assign rd_word = rd_old;
    end
  endgenerate

  // First read stage. Data only loads on an accepted access so that douta
  // holds its last value between pulses.
  logic [DATA_W-1:0] s1_data;
  logic              s1_vld;

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_data <= rd_word;
      end
    end
  end

`ifdef SP_RAM_ARRAY_OUTREG_EN
  logic [DATA_W-1:0] s2_data;
  logic              s2_vld;

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      s2_data <= '0;
      s2_vld  <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_data <= s1_data;
      end
    end
  end

  assign douta     = s2_data;
  assign douta_vld = s2_vld;
`else
  assign douta     = s1_data;
  assign douta_vld = s1_vld;
`endif

endmodule : sp_ram_array
`default_nettype wire

// File: tb/tb_sp_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_array
// Purpose  : Self-checking bench for sp_ram_array. Two instances (read-first
//            and write-first) share the same stimulus and are compared
//            against a word-level reference model every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_sp_ram_array;

  localparam int DW    = 72;
  localparam int AW    = 4;
  localparam int LW    = 8;
  localparam int NL    = 9;
  localparam int DEPTH = 16;
`ifdef SP_RAM_ARRAY_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [LW-1:0] CLR_B = 8'h3C;
  localparam logic [DW-1:0] CLRW  = {NL{CLR_B}};
  localparam logic [DW-1:0] AA9   = {NL{8'hAA}};
  localparam logic [DW-1:0] AA11  = {{8{8'hAA}}, 8'h11};
  localparam logic [DW-1:0] W55   = {NL{8'h55}};
  localparam logic [DW-1:0] WFF   = {NL{8'hFF}};
  localparam logic [NL-1:0] ALL   = '1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena   = 1'b0;
  logic          clr   = 1'b0;
  logic [NL-1:0] wea   = '0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] din   = '0;

  logic [DW-1:0] dout_rf, dout_wf;
  logic          vld_rf, vld_wf, busy_rf, busy_wf;

  always #5 clk = ~clk;

  sp_ram_array #(
    .DATA_W (DW), .ADDR_W (AW), .LANE_W (LW), .RD_MODE (0), .CLR_VAL (CLR_B)
  ) dut_rf (
    .clka (clk), .rsta (rst_n), .ena (ena), .wea (wea), .addra (addr),
    .dina (din), .clr_req (clr), .douta (dout_rf), .douta_vld (vld_rf),
    .busy (busy_rf)
  );

  sp_ram_array #(
    .DATA_W (DW), .ADDR_W (AW), .LANE_W (LW), .RD_MODE (1), .CLR_VAL (CLR_B)
  ) dut_wf (
    .clka (clk), .rsta (rst_n), .ena (ena), .wea (wea), .addra (addr),
    .dina (din), .clr_req (clr), .douta (dout_wf), .douta_vld (vld_wf),
    .busy (busy_wf)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] d_rf;
    logic [DW-1:0] d_wf;
  } pend_t;

  logic [DW-1:0] m_mem [DEPTH];
  pend_t         pq[$];
  int            clear_left = DEPTH;  // sweep cycles still to run
  int            cyc = 0;
  logic          m_vld = 1'b0;
  logic [DW-1:0] m_dout_rf = '0;
  logic [DW-1:0] m_dout_wf = '0;

  int checks = 0;
  int failures = 0;

  task automatic model_edge();
    logic [DW-1:0] old_w, new_w;
    pend_t         p;
    cyc++;
    if (!rst_n) begin
      pq.delete();
      m_dout_rf  = '0;
      m_dout_wf  = '0;
      m_vld      = 1'b0;
      clear_left = DEPTH;
      return;
    end
    if (clear_left > 0) begin
      m_mem[DEPTH - clear_left] = CLRW;
      clear_left--;
    end else begin
      if (ena) begin
        old_w = m_mem[addr];
        new_w = old_w;
        for (int l = 0; l < NL; l++)
          if (wea[l]) new_w[l*LW +: LW] = din[l*LW +: LW];
        m_mem[addr] = new_w;
        p.due  = cyc + LAT - 1;
        p.d_rf = old_w;
        p.d_wf = new_w;
        pq.push_back(p);
      end
      if (clr) clear_left = DEPTH;
    end
    m_vld = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      m_vld     = 1'b1;
      m_dout_rf = pq[0].d_rf;
      m_dout_wf = pq[0].d_wf;
      void'(pq.pop_front());
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0b expected=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk1("busy_rf", busy_rf, clear_left > 0);
    chk1("busy_wf", busy_wf, clear_left > 0);
    chk1("vld_rf", vld_rf, m_vld);
    chk1("vld_wf", vld_wf, m_vld);
    chkw("dout_rf", dout_rf, m_dout_rf);
    chkw("dout_wf", dout_wf, m_dout_wf);
  endtask

  task automatic cycle(input logic e, input logic [NL-1:0] w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic c);
    ena = e; wea = w; addr = a; din = d; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic do_reset(input int hold);
    ena = 1'b0; wea = '0; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_vld", vld_rf, 1'b0);
    chkw("async_rst_dout", dout_rf, '0);
    chk1("async_rst_busy", busy_rf, 1'b1);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      chkw("rst_dout", dout_rf, '0);
      chk1("rst_vld", vld_rf, 1'b0);
    end
    rst_n = 1'b1;
  endtask

  // Counts edges until busy drops; vld_busy counts pulses seen while busy
  // that cannot belong to an access issued before the sweep.
  task automatic count_busy(input logic drive_ena, output int n, output int vld_busy);
    n = 0;
    vld_busy = 0;
    for (int k = 0; k < 4 * DEPTH; k++) begin
      if (drive_ena) cycle(1'b1, NL'($urandom()), AW'($urandom()), rand_word(), 1'b0);
      else idle();
      n++;
      if (k >= LAT - 1 && busy_rf && (vld_rf || vld_wf)) vld_busy++;
      if (!busy_rf) break;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NL-1:0] wea;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_rf;
    logic [DW-1:0] exp_wf;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n, vb, pulses, first_c, last_c;

    tbl[0] = '{ALL,    4'd5,  AA9,           CLRW, AA9};
    tbl[1] = '{9'h001, 4'd5,  72'h11,        AA9,  AA11};
    tbl[2] = '{9'h000, 4'd5,  '0,            AA11, AA11};
    tbl[3] = '{ALL,    4'd7,  '0,            CLRW, '0};
    tbl[4] = '{ALL,    4'd7,  W55,           '0,   W55};
    tbl[5] = '{9'h000, 4'd7,  '0,            W55,  W55};
    tbl[6] = '{9'h100, 4'd2,  {8'hCC, 64'h0}, CLRW, {8'hCC, {8{CLR_B}}}};
    tbl[7] = '{9'h000, 4'd15, '0,            CLRW, CLRW};

    // Power-up reset and first sweep
    #1;
    do_reset(3);
    count_busy(1'b0, n, vb);
    chki("busy_len_after_reset", n, DEPTH);

    // Every word reads back the clear value
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, '0, AW'(i), '0, 1'b0);
    for (int k = 0; k < LAT; k++) idle();

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].wea, tbl[i].addr, tbl[i].din, 1'b0);
      for (int k = 1; k < LAT; k++) idle();
      chk1($sformatf("tbl%0d_vld", i), vld_rf, 1'b1);
      chkw($sformatf("tbl%0d_rf", i), dout_rf, tbl[i].exp_rf);
      chkw($sformatf("tbl%0d_wf", i), dout_wf, tbl[i].exp_wf);
      idle();
    end

    // 20 back-to-back reads: pulses must be contiguous
    pulses = 0; first_c = -1; last_c = -1;
    for (int i = 0; i < 20 + LAT; i++) begin
      if (i < 20) cycle(1'b1, '0, AW'(i % DEPTH), rand_word(), 1'b0);
      else idle();
      if (vld_rf) begin
        pulses++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
    end
    chki("b2b_pulses", pulses, 20);
    chki("b2b_span", last_c - first_c, 19);

    // Clear request with accesses hammering during the sweep
    cycle(1'b1, ALL, 4'd3, WFF, 1'b0);
    cycle(1'b1, '0, 4'd3, '0, 1'b1);
    count_busy(1'b1, n, vb);
    chki("busy_len_clr_req", n, DEPTH);
    chki("vld_while_busy", vb, 0);
    cycle(1'b1, '0, 4'd3, '0, 1'b0);
    for (int k = 1; k < LAT; k++) idle();
    chkw("addr3_after_clear", dout_rf, CLRW);
    idle();

    // clr_req while busy must not restart the sweep
    cycle(1'b0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 5; k++) idle();
    cycle(1'b0, '0, '0, '0, 1'b1);
    count_busy(1'b0, n, vb);
    chki("busy_len_ignored_req", n, DEPTH - 6);

    // Reset in the middle of a sweep (clr_cnt = 6)
    cycle(1'b0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 6; k++) idle();
    do_reset(3);
    count_busy(1'b0, n, vb);
    chki("busy_len_mid_reset", n, DEPTH);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? NL'($urandom()) : '0,
            AW'($urandom()), rand_word(),
            $urandom_range(0, 79) == 0);
    end
    for (int k = 0; k < DEPTH + LAT + 2; k++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule : tb_sp_ram_array
`default_nettype wire
